// File: rtl/i2c_state_pkg.sv
// i2c_state_pkg: shared widths, ACK slot index and transfer-state encoding for the I2C bus monitor.
package i2c_state_pkg;
    localparam int I2C_BIT_CNT_W = 4;
    localparam logic [I2C_BIT_CNT_W-1:0] I2C_ACK_SLOT = 4'd8;
    localparam int I2C_ADDR_W = 7;
    typedef enum logic [1:0] {MON_IDLE, MON_ADDR, MON_XFER} mon_state_t;
endpackage

// File: rtl/i2c_input_filter.sv
// i2c_input_filter: pad synchroniser plus optional stability filter (I2C_GLITCH_FILTER_EN).
module i2c_input_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic filt
);
    logic [SYNC_STAGES-1:0] sync;
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_bad_param
        $error("i2c_input_filter: SYNC_STAGES must be 2..4 and FILTER_LEN 1..15");
    end
    always_ff @(posedge clk)
        if (rst) sync <= '1;
        else sync <= {sync[SYNC_STAGES-2:0], raw};
`ifdef I2C_GLITCH_FILTER_EN
    logic [3:0] run;
    // run counts consecutive cycles the synchronised value disagrees with filt
    always_ff @(posedge clk) begin
        if (rst) begin
            run <= '0;
            filt <= 1'b1;
        end else if (sync[SYNC_STAGES-1] == filt) begin
            run <= '0;
        end else if (run == 4'(FILTER_LEN - 1)) begin
            run <= '0;
            filt <= sync[SYNC_STAGES-1];
        end else begin
            run <= run + 4'd1;
        end
    end
`else
    assign filt = sync[SYNC_STAGES-1];
`endif
endmodule

// File: rtl/i2c_bus_monitor.sv
// i2c_bus_monitor: START/STOP detection, bit counting, byte capture and address decode.
// Define I2C_GLITCH_FILTER_EN to add the FILTER_LEN stability filter on both pads.
module i2c_bus_monitor
    import i2c_state_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN = 3,
    parameter logic [I2C_ADDR_W-1:0] DEV_ADDR = 7'h3C
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     scl_in,
    input  logic                     sda_in,
    output logic                     scl_rise,
    output logic                     scl_fall,
    output logic                     start_cond,
    output logic                     stop_cond,
    output logic                     bus_busy,
    output logic [I2C_BIT_CNT_W-1:0] clock_count,
    output logic [7:0]               rx_byte,
    output logic                     byte_valid,
    output logic                     address_match,
    output logic                     read_bit,
    output logic                     write_bit,
    output logic                     received_nack
);
    logic scl_f, sda_f, scl_p, sda_p;
    logic rise_c, fall_c, start_c, stop_c, bit_rise, byte_done;
    logic [6:0] shreg;
    logic [7:0] byte_c;
    mon_state_t state, state_n;

    i2c_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl (
        .clk(clk), .rst(rst), .raw(scl_in), .filt(scl_f)
    );
    i2c_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda (
        .clk(clk), .rst(rst), .raw(sda_in), .filt(sda_f)
    );

    // SDA edges only count as conditions when SCL is high in both samples
    assign rise_c    = ~scl_p & scl_f;
    assign fall_c    = scl_p & ~scl_f;
    assign start_c   = scl_p & scl_f & sda_p & ~sda_f;
    assign stop_c    = scl_p & scl_f & ~sda_p & sda_f;
    assign bit_rise  = rise_c & (state != MON_IDLE);
    assign byte_done = bit_rise & (clock_count == 4'd7);
    assign byte_c    = {shreg, sda_f};
    assign bus_busy  = state != MON_IDLE;

    always_comb begin
        state_n = start_c ? MON_ADDR :
                  stop_c ? MON_IDLE :
                  (byte_done && state == MON_ADDR) ? MON_XFER : state;
    end

    always_ff @(posedge clk)
        if (rst) state <= MON_IDLE;
        else state <= state_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_p <= 1'b1;
            sda_p <= 1'b1;
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
            start_cond <= 1'b0;
            stop_cond <= 1'b0;
            byte_valid <= 1'b0;
            clock_count <= '0;
            shreg <= '0;
            rx_byte <= '0;
            address_match <= 1'b0;
            read_bit <= 1'b0;
            write_bit <= 1'b0;
            received_nack <= 1'b0;
        end else begin
            scl_p <= scl_f;
            sda_p <= sda_f;
            scl_rise <= rise_c;
            scl_fall <= fall_c;
            start_cond <= start_c;
            stop_cond <= stop_c;
            byte_valid <= byte_done & ~start_c & ~stop_c;
            if (start_c || stop_c) begin
                clock_count <= '0;
                shreg <= '0;
                address_match <= 1'b0;
                read_bit <= 1'b0;
                write_bit <= 1'b0;
                received_nack <= 1'b0;
            end else if (bit_rise) begin
                clock_count <= (clock_count == I2C_ACK_SLOT) ? '0 : clock_count + 4'd1;
                if (clock_count != I2C_ACK_SLOT) shreg <= byte_c[6:0];
                if (byte_done) rx_byte <= byte_c;
                if (byte_done && state == MON_ADDR) begin
                    address_match <= byte_c[7:1] == DEV_ADDR;
                    read_bit <= byte_c[0];
                    write_bit <= ~byte_c[0];
                end
                if (clock_count == I2C_ACK_SLOT && state == MON_XFER && read_bit && sda_f)
                    received_nack <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_i2c_bus_monitor.sv
// tb_i2c_bus_monitor: randomized I2C traffic checked every cycle against a behavioural model,
// plus literal checks of the directed scenarios.
module tb_i2c_bus_monitor;
    localparam int S = 2;
    localparam int L = 3;
    localparam logic [6:0] ADDR = 7'h3C;

    logic clk = 1'b0, rst = 1'b1, scl_in = 1'b1, sda_in = 1'b1;
    logic scl_rise, scl_fall, start_cond, stop_cond, bus_busy, byte_valid;
    logic address_match, read_bit, write_bit, received_nack;
    logic [3:0] clock_count;
    logic [7:0] rx_byte;

    i2c_bus_monitor #(.SYNC_STAGES(S), .FILTER_LEN(L), .DEV_ADDR(ADDR)) dut (
        .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in),
        .scl_rise(scl_rise), .scl_fall(scl_fall), .start_cond(start_cond), .stop_cond(stop_cond),
        .bus_busy(bus_busy), .clock_count(clock_count), .rx_byte(rx_byte), .byte_valid(byte_valid),
        .address_match(address_match), .read_bit(read_bit), .write_bit(write_bit),
        .received_nack(received_nack)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0, n_start = 0;
    logic [7:0] rxq[$];

    // model state: pad delay lines, filtered/previous levels, transfer bookkeeping
    bit qs[$], qd[$];
    bit fs, fd, ps, pd;
    int runs, rund, m_cnt;
    bit m_busy, m_addr, m_rise, m_fall, m_st, m_sp, m_bv, m_match, m_rd, m_wr, m_nack;
    logic [7:0] m_sh, m_rx;

    task automatic filt_step(inout bit f, inout int run, input bit v);
        if (v == f) run = 0;
        else begin
            run++;
            if (run >= L) begin f = v; run = 0; end
        end
    endtask

    task automatic model_step();
        bit vs, vd, cs, cd;
        if (rst) begin
            qs = {}; qd = {};
            for (int i = 0; i < S; i++) begin qs.push_back(1'b1); qd.push_back(1'b1); end
            fs = 1; fd = 1; ps = 1; pd = 1; runs = 0; rund = 0; m_cnt = 0;
            {m_busy, m_addr, m_rise, m_fall, m_st, m_sp, m_bv, m_match, m_rd, m_wr, m_nack} = '0;
            m_sh = 0; m_rx = 0;
            return;
        end
        qs.push_back(scl_in); qd.push_back(sda_in);
        vs = qs.pop_front(); vd = qd.pop_front();
`ifdef I2C_GLITCH_FILTER_EN
        cs = fs; cd = fd;
        filt_step(fs, runs, vs);
        filt_step(fd, rund, vd);
`else
        cs = vs; cd = vd;
`endif
        m_rise = !ps && cs;
        m_fall = ps && !cs;
        m_st = ps && cs && pd && !cd;
        m_sp = ps && cs && !pd && cd;
        m_bv = 0;
        if (m_st || m_sp) begin
            m_busy = m_st; m_addr = m_st; m_cnt = 0; m_sh = 0;
            {m_match, m_rd, m_wr, m_nack} = '0;
        end else if (m_rise && m_busy) begin
            if (m_cnt == 8) begin
                if (!m_addr && m_rd && cd) m_nack = 1;
                m_cnt = 0;
            end else begin
                m_sh = {m_sh[6:0], cd};
                if (m_cnt == 7) begin
                    m_rx = m_sh; m_bv = 1;
                    if (m_addr) begin
                        m_match = m_sh[7:1] == ADDR; m_rd = m_sh[0]; m_wr = !m_sh[0]; m_addr = 0;
                    end
                end
                m_cnt++;
            end
        end
        ps = cs; pd = cd;
    endtask

    initial begin
        logic [21:0] act, want;
        forever begin
            @(posedge clk);
            model_step();
            #1;
            act = {scl_rise, scl_fall, start_cond, stop_cond, bus_busy, clock_count, rx_byte,
                   byte_valid, address_match, read_bit, write_bit, received_nack};
            want = {m_rise, m_fall, m_st, m_sp, m_busy, 4'(m_cnt), m_rx,
                    m_bv, m_match, m_rd, m_wr, m_nack};
            vectors++;
            if (act !== want) begin
                miscompares++;
                $display("FAIL cycle-compare t=%0t: dut=%h model=%h", $time, act, want);
            end
            if (start_cond === 1'b1) n_start++;
            if (byte_valid === 1'b1) rxq.push_back(rx_byte);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp_v);
        vectors++;
        if (got !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp_v);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input bit c, input bit d);
        @(negedge clk);
        scl_in = c; sda_in = d;
        repeat ($urandom_range(3, 6)) @(negedge clk);
    endtask

    task automatic send_bit(input bit b);
        drive(0, b); drive(1, b); drive(0, b);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic i2c_start();
        drive(0, 1); drive(1, 1); drive(1, 0); drive(0, 0);
    endtask

    task automatic i2c_stop();
        drive(0, 0); drive(1, 0); drive(1, 1);
    endtask

    initial begin
        int n0;
        logic [7:0] b;
        settle(3);
        check("reset_outputs", {scl_rise, scl_fall, start_cond, stop_cond, bus_busy, clock_count,
              rx_byte, byte_valid, address_match, read_bit, write_bit, received_nack}, 0);
        rst = 0;
        settle(10);
        check("no_spurious_start", n_start, 0);

        n0 = n_start; rxq.delete();
        i2c_start(); send_byte(8'h78); settle(12);
        check("ack_slot_count", clock_count, 8);
        send_bit(0); settle(12);
        check("wr_match", address_match, 1);
        check("wr_write_bit", write_bit, 1);
        check("wr_read_bit", read_bit, 0);
        check("wr_count_wrapped", clock_count, 0);
        send_byte(8'hA5); send_bit(0); i2c_stop(); settle(12);
        check("wr_byte_count", rxq.size(), 2);
        check("wr_rx0", rxq.size() > 0 ? rxq[0] : 8'hxx, 8'h78);
        check("wr_rx1", rxq.size() > 1 ? rxq[1] : 8'hxx, 8'hA5);
        check("wr_start_pulses", n_start - n0, 1);
        check("wr_flags_after_stop", {bus_busy, address_match, read_bit, write_bit, received_nack}, 0);

        i2c_start(); send_byte(8'h7B); send_bit(1); send_byte(8'h5A); send_bit(1); settle(12);
        check("rd_match", address_match, 0);
        check("rd_read_bit", read_bit, 1);
        check("rd_nack", received_nack, 1);
        i2c_stop(); settle(12);
        check("rd_nack_cleared", received_nack, 0);

        i2c_start(); send_byte(8'h78); send_bit(0); settle(12);
        check("rs_first_match", address_match, 1);
        n0 = n_start;
        i2c_start(); settle(12);
        check("rs_start_pulse", n_start - n0, 1);
        check("rs_state", {bus_busy, clock_count, address_match, write_bit}, {1'b1, 4'd0, 2'b00});
        send_byte(8'h79); send_bit(0); settle(12);
        check("rs_redecode", {address_match, read_bit, write_bit}, 3'b110);
        i2c_stop(); settle(10);

        i2c_start();
        for (int i = 0; i < 5; i++) send_bit(1);
        settle(12);
        check("mid_count5", clock_count, 5);
        @(negedge clk); rst = 1; scl_in = 1; sda_in = 1;
        settle(2); rst = 0; settle(10);
        check("post_reset_idle", {bus_busy, clock_count}, 0);
        i2c_start(); send_byte(8'h78); settle(12);
        check("post_reset_rx", rx_byte, 8'h78);
        i2c_stop(); settle(10);

`ifdef I2C_GLITCH_FILTER_EN
        n0 = n_start;
        @(negedge clk); sda_in = 0; settle(2); sda_in = 1; settle(15);
        check("glitch2_no_start", n_start - n0, 0);
        @(negedge clk); sda_in = 0; settle(4); sda_in = 1; settle(15);
        check("glitch4_start", n_start - n0, 1);
`endif

        for (int t = 0; t < 8; t++) begin
            i2c_start();
            b = ($urandom_range(0, 1) == 1) ? {ADDR, 1'($urandom)} : 8'($urandom);
            send_byte(b); send_bit(1'($urandom));
            for (int k = $urandom_range(1, 3); k > 0; k--) begin
                send_byte(8'($urandom)); send_bit(1'($urandom));
            end
            if ($urandom_range(0, 3) == 0) begin
                i2c_start(); send_byte({ADDR, 1'($urandom)}); send_bit(1'($urandom));
            end
            i2c_stop(); settle($urandom_range(2, 10));
        end
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) scl_in = 1'($urandom);
            if ($urandom_range(0, 3) == 0) sda_in = 1'($urandom);
        end
        scl_in = 1; sda_in = 1; settle(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end
endmodule

// File: doc/i2c_bus_monitor.md
Name: i2c_bus_monitor

Overview:
- System-clock front end for the I2C subordinate; sits directly upstream of the SCL-driven subordinate state machine.
- Synchronises and optionally deglitches raw SCL/SDA pad inputs, and detects START/STOP conditions.
- Counts bit positions, assembles received bytes, and decodes the address byte.
- Produces start_cond, stop_cond, clock_count, address_match, read_bit, write_bit and received_nack for the downstream state machine.

Parameters:
- SYNC_STAGES, 2: synchroniser depth per pad input; legal values 2..4.
- FILTER_LEN, 3: consecutive stable clk cycles required before a filtered input changes; legal values 1..15; used only with the glitch filter.
- DEV_ADDR, 7'h3C: 7-bit device address compared against the first byte after START.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- scl_in  in  1  raw SCL pad input, asynchronous
- sda_in  in  1  raw SDA pad input, asynchronous
- scl_rise  out  1  one-cycle pulse on a filtered SCL rising edge
- scl_fall  out  1  one-cycle pulse on a filtered SCL falling edge
- start_cond  out  1  one-cycle pulse on START or repeated START
- stop_cond  out  1  one-cycle pulse on STOP
- bus_busy  out  1  high between START and STOP
- clock_count  out  4  bit position within the current byte frame, 0..8; 8 is the ACK slot
- rx_byte  out  8  last fully received byte, MSB first
- byte_valid  out  1  one-cycle pulse when rx_byte updates
- address_match  out  1  address byte matched DEV_ADDR
- read_bit  out  1  R/W bit of the address byte was 1
- write_bit  out  1  R/W bit of the address byte was 0
- received_nack  out  1  master returned NACK (SDA=1) in the ACK slot of a read transfer

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - Synchroniser flops and filtered SCL/SDA go to 1 (idle bus).
  - All pulse outputs, bus_busy, clock_count, rx_byte, address_match, read_bit, write_bit and received_nack go to 0.
  - Reset mid-transfer discards all progress; monitoring restarts idle.
- Input path:
  - Each input passes through SYNC_STAGES flops.
  - The filtered value takes the synchronised value only after it has differed from the current filtered value for FILTER_LEN consecutive cycles; the stability counter clears on any bounce.
- Edge and condition detection compares the previous and current filtered values; all outputs are registered.
  - scl_rise = SCL 0→1; scl_fall = SCL 1→0.
  - start_cond = SDA 1→0 while SCL is 1 in both the previous and current sample.
  - stop_cond = SDA 1→0 replaced by SDA 0→1 under the same SCL condition.
  - If SCL and SDA change in the same cycle, neither start_cond nor stop_cond fires; the SCL edge pulse still fires.
- Latency from pad change to output pulse, in clk edges:
  - SYNC_STAGES+1 without the filter.
  - SYNC_STAGES+FILTER_LEN+1 with the filter.
- Transfer-state control (internal, 3 states):
  - MON_IDLE → MON_ADDR on start_cond.
  - MON_ADDR → MON_XFER when the address byte completes.
  - Any state → MON_ADDR on start_cond (repeated START).
  - Any state → MON_IDLE on stop_cond.
  - bus_busy=1 outside MON_IDLE.
- Bit counter:
  - start_cond clears clock_count to 0.
  - scl_rise with clock_count<8 increments it.
  - scl_rise with clock_count==8 wraps it to 0.
  - scl_rise in MON_IDLE has no effect.
- Byte capture:
  - On scl_rise with clock_count 0..7, filtered SDA shifts into the shift register LSB; MSB is received first.
  - On the scl_rise with clock_count==7, rx_byte loads the completed byte and byte_valid pulses the next cycle.
- Address decode, on byte completion in MON_ADDR:
  - address_match = (byte[7:1]==DEV_ADDR).
  - read_bit = byte[0]; write_bit = ~byte[0].
  - These values hold until the next start_cond or stop_cond, which clear them to 0.
- NACK detection:
  - On scl_rise with clock_count==8, in MON_XFER, with read_bit=1, received_nack is set if filtered SDA=1.
  - It is sticky until start_cond or stop_cond.
- Simultaneous events: rst beats start_cond; start_cond beats stop_cond, which cannot co-occur by construction; start_cond or stop_cond beats scl_rise counting.

Optional Feature:
- I2C_GLITCH_FILTER_EN defined: the FILTER_LEN stability filter is instantiated on both inputs.
- Undefined: the filtered value equals the synchroniser output; FILTER_LEN is ignored; latency is SYNC_STAGES+1.

Decomposition:
- i2c_state_pkg gains:
  - I2C_BIT_CNT_W=4
  - I2C_ACK_SLOT=4'd8
  - I2C_ADDR_W=7
  - typedef enum mon_state_t {MON_IDLE, MON_ADDR, MON_XFER}
- Sub-module i2c_input_filter (synchroniser plus optional stability filter) is instantiated once for SCL and once for SDA.

Test Plan:
- Reset held 3 cycles with pads idle high → all outputs 0, bus_busy=0, no spurious start_cond.
- START, write to address 0x3C (byte 0x78), ACK, data byte 0xA5, STOP:
  - start_cond pulses once.
  - byte_valid fires twice with rx_byte 0x78 then 0xA5.
  - address_match=1, write_bit=1.
  - clock_count wraps 8→0.
  - stop_cond clears all flags.
- Address 0x3D + read, then master NACK (SDA=1) in the ACK slot → address_match=0, read_bit=1, received_nack=1 until STOP.
- Repeated START after the address byte, without STOP:
  - start_cond pulses; clock_count=0; address flags cleared; bus_busy stays 1.
  - A new address byte re-decodes.
- I2C_GLITCH_FILTER_EN with FILTER_LEN=3: a 2-cycle SDA low pulse while SCL=1 → no start_cond; a 4-cycle pulse → start_cond.
- rst asserted mid-byte at clock_count=5, then a new START → counter restarts at 0; the first rx_byte contains only post-reset bits.
